// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory-side blocks.
//   WORD_W          : instruction/data word width in bits
//   ADDR_W_DEFAULT  : default word-address width of the instruction memory
//   loader_state_t  : state encoding of the program loader FSM
package cpu_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned ADDR_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWrite,
    StDone
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into big-endian 32-bit words (first byte lands in [31:24]).
// Ports:
//   clk_i        : clock
//   rst_ni       : synchronous active-low reset
//   clear_i      : drop any partial word and restart at byte 0 (wins over shift_i)
//   shift_i      : accept byte_i this cycle
//   byte_i       : stream byte
//   word_o       : shift register contents (full word once four bytes are in)
//   word_full_o  : this cycle's shift completes a word
module byte_packer
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clear_i) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (shift_i) begin
      sr_d  = {sr_q[WORD_W-9:0], byte_i};
      // Two-bit counter wraps to 0 after the fourth byte, ready for the next word.
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign word_o      = sr_q;
  assign word_full_o = shift_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Loads a program into instruction memory from a byte stream at run time.
// Bytes are packed big-endian into 32-bit words; each word is written in a
// one-cycle WRITE state to base + words_written (wrapping modulo 2^ADDR_W).
// Ports:
//   in_clk / in_reset_n        : clock, synchronous active-low reset
//   in_start / in_abort        : begin a load (IDLE/DONE) / cancel it (LOAD/WRITE)
//   in_base_addr/in_word_count : load parameters, sampled on accepted start
//   in_byte/in_byte_valid      : stream input; out_byte_ready is its ready
//   out_we/out_waddr/out_wdata : instruction memory write port
//   out_busy/out_done          : status (LOAD or WRITE / DONE)
//   out_words_written          : words committed in the current or last load
module instruction_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W_DEFAULT
) (
  input  logic              in_clk,
  input  logic              in_reset_n,
  input  logic              in_start,
  input  logic              in_abort,
  input  logic [ADDR_W-1:0] in_base_addr,
  input  logic [ADDR_W:0]   in_word_count,
  input  logic [7:0]        in_byte,
  input  logic              in_byte_valid,
  output logic              out_byte_ready,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_waddr,
  output logic [WORD_W-1:0] out_wdata,
  output logic              out_busy,
  output logic              out_done,
  output logic [ADDR_W:0]   out_words_written
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  logic              start_ok, abort_ok;
  logic              pk_shift, pk_clear, pk_full;
  logic [WORD_W-1:0] pk_word;

  assign start_ok = in_start && ((state_q == StIdle) || (state_q == StDone));
  assign abort_ok = in_abort && ((state_q == StLoad) || (state_q == StWrite));
  assign pk_shift = in_byte_valid && (state_q == StLoad);
  assign pk_clear = start_ok || abort_ok;

  byte_packer u_byte_packer (
    .clk_i       (in_clk),
    .rst_ni      (in_reset_n),
    .clear_i     (pk_clear),
    .shift_i     (pk_shift),
    .byte_i      (in_byte),
    .word_o      (pk_word),
    .word_full_o (pk_full)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    words_d = words_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          base_d  = in_base_addr;
          count_d = in_word_count;
          words_d = '0;
          state_d = (in_word_count == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (abort_ok) begin
          state_d = StIdle;
        end else if (pk_full) begin
          // Register the write port now so it is stable for the whole WRITE cycle.
          state_d = StWrite;
          waddr_d = base_q + words_q[ADDR_W-1:0];
          wdata_d = {pk_word[WORD_W-9:0], in_byte};
        end
      end
      StWrite: begin
        // The write happens this cycle regardless of abort, so it is always counted.
        words_d = words_q + 1'b1;
        if (abort_ok) begin
          state_d = StIdle;
        end else if ((words_q + 1'b1) == count_q) begin
          state_d = StDone;
        end else begin
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_reset_n) begin
      state_q <= StIdle;
      base_q  <= '0;
      count_q <= '0;
      words_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      words_q <= words_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign out_byte_ready    = (state_q == StLoad);
  assign out_we            = (state_q == StWrite);
  assign out_busy          = (state_q == StLoad) || (state_q == StWrite);
  assign out_done          = (state_q == StDone);
  assign out_waddr         = waddr_q;
  assign out_wdata         = wdata_q;
  assign out_words_written = words_q;

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] base;
  logic [16:0] cnt;
  logic [7:0]  byte_in;
  logic        valid;
  logic        out_byte_ready;
  logic        out_we;
  logic [15:0] out_waddr;
  logic [31:0] out_wdata;
  logic        out_busy;
  logic        out_done;
  logic [16:0] out_words_written;

  int total;
  int bad;

  // Expected writes: {addr[15:0], data[31:0]}, pushed when a load is issued.
  logic [47:0] exp_q[$];
  logic [47:0] mon_e;

  instruction_loader #(.ADDR_W(16)) dut (
    .in_clk            (clk),
    .in_reset_n        (rst_n),
    .in_start          (start),
    .in_abort          (abort),
    .in_base_addr      (base),
    .in_word_count     (cnt),
    .in_byte           (byte_in),
    .in_byte_valid     (valid),
    .out_byte_ready    (out_byte_ready),
    .out_we            (out_we),
    .out_waddr         (out_waddr),
    .out_wdata         (out_wdata),
    .out_busy          (out_busy),
    .out_done          (out_done),
    .out_words_written (out_words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 out_waddr, out_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", {48'd0, out_waddr}, {48'd0, mon_e[47:32]});
        chk("write_data", {32'd0, out_wdata}, {32'd0, mon_e[31:0]});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end just after a falling edge.
  task automatic pulse_start(input logic [15:0] b, input logic [16:0] c, input logic ab);
    start = 1'b1;
    abort = ab;
    base  = b;
    cnt   = c;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit last, input string tag);
    bit ok;
    valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in = b;
    valid   = 1'b1;
    ok      = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (out_byte_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s_byte_timeout: got no ready expected ready", tag);
    end
    @(negedge clk);
    if (last) chk({tag, "_we_latency"}, {63'd0, out_we}, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input string tag);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gap, (k == 3), tag);
    valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && !out_done; i++) @(negedge clk);
    chk({tag, "_done"}, {63'd0, out_done}, 64'd1);
  endtask

  task automatic push(input logic [15:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    start   = 1'b1;
    abort   = 1'b0;
    base    = 16'h1234;
    cnt     = 17'd3;
    byte_in = 8'hFF;
    valid   = 1'b1;

    // Reset held for three cycles with start/valid active.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", {63'd0, out_byte_ready}, 64'd0);
      chk("rst_we",    {63'd0, out_we},         64'd0);
      chk("rst_busy",  {63'd0, out_busy},       64'd0);
      chk("rst_done",  {63'd0, out_done},       64'd0);
    end
    chk("rst_words", {47'd0, out_words_written}, 64'd0);
    chk("rst_waddr", {48'd0, out_waddr},         64'd0);
    chk("rst_wdata", {32'd0, out_wdata},         64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", {63'd0, out_byte_ready}, 64'd0);
    chk("idle_busy",  {63'd0, out_busy},       64'd0);

    // Basic two-word load, valid always high.
    push(16'h0010, 32'h8C220004);
    push(16'h0011, 32'hAC430008);
    pulse_start(16'h0010, 17'd2, 1'b0);
    chk("basic_busy",  {63'd0, out_busy},       64'd1);
    chk("basic_ready", {63'd0, out_byte_ready}, 64'd1);
    send_word(32'h8C220004, 0, "basic1");
    send_word(32'hAC430008, 0, "basic2");
    @(negedge clk);
    chk("basic_done",   {63'd0, out_done},          64'd1);
    chk("basic_words",  {47'd0, out_words_written}, 64'd2);
    chk("basic_we_off", {63'd0, out_we},            64'd0);
    chk("basic_ready0", {63'd0, out_byte_ready},    64'd0);
    chk("basic_hold",   {48'd0, out_waddr},         64'h0011);

    // Gaps in the stream; bytes held while in WRITE.
    push(16'h0020, 32'hDEADBEEF);
    push(16'h0021, 32'h01020304);
    push(16'h0022, 32'hA5A55A5A);
    pulse_start(16'h0020, 17'd3, 1'b0);
    send_word(32'hDEADBEEF, 1, "gap1");
    send_word(32'h01020304, 2, "gap2");
    send_word(32'hA5A55A5A, 3, "gap3");
    wait_done("gap");
    chk("gap_words", {47'd0, out_words_written}, 64'd3);

    // Address wraps past the top of memory.
    push(16'hFFFF, 32'h11112222);
    push(16'h0000, 32'h33334444);
    pulse_start(16'hFFFF, 17'd2, 1'b0);
    send_word(32'h11112222, 0, "wrap1");
    send_word(32'h33334444, 0, "wrap2");
    wait_done("wrap");

    // Abort after six bytes of a three-word load.
    push(16'h0100, 32'hCAFEF00D);
    pulse_start(16'h0100, 17'd3, 1'b0);
    send_word(32'hCAFEF00D, 0, "abort1");
    send_byte(8'h12, 0, 1'b0, "abort2");
    send_byte(8'h34, 0, 1'b0, "abort2");
    valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy",  {63'd0, out_busy},          64'd0);
    chk("abort_done",  {63'd0, out_done},          64'd0);
    chk("abort_words", {47'd0, out_words_written}, 64'd1);
    chk("abort_ready", {63'd0, out_byte_ready},    64'd0);
    push(16'h0200, 32'h0BADC0DE);
    pulse_start(16'h0200, 17'd1, 1'b0);
    send_word(32'h0BADC0DE, 0, "restart");
    wait_done("restart");
    chk("restart_words", {47'd0, out_words_written}, 64'd1);

    // Zero-length load goes straight to DONE without writing.
    pulse_start(16'h0300, 17'd0, 1'b0);
    chk("zero_done",  {63'd0, out_done},          64'd1);
    chk("zero_busy",  {63'd0, out_busy},          64'd0);
    chk("zero_words", {47'd0, out_words_written}, 64'd0);
    repeat (3) @(negedge clk);

    // Start during LOAD is ignored.
    push(16'h0400, 32'h55667788);
    pulse_start(16'h0400, 17'd1, 1'b0);
    send_byte(8'h55, 0, 1'b0, "ign");
    send_byte(8'h66, 0, 1'b0, "ign");
    valid = 1'b0;
    pulse_start(16'h0500, 17'd5, 1'b0);
    send_byte(8'h77, 0, 1'b0, "ign");
    send_byte(8'h88, 0, 1'b1, "ign");
    valid = 1'b0;
    wait_done("ign");
    chk("ign_words", {47'd0, out_words_written}, 64'd1);

    // Start and abort together from DONE: start wins.
    push(16'h0600, 32'h9ABCDEF0);
    pulse_start(16'h0600, 17'd1, 1'b1);
    chk("sa_busy", {63'd0, out_busy}, 64'd1);
    send_word(32'h9ABCDEF0, 0, "sa");
    wait_done("sa");

    // Reset mid-load clears the word count.
    push(16'h0700, 32'h0F0E0D0C);
    pulse_start(16'h0700, 17'd2, 1'b0);
    send_word(32'h0F0E0D0C, 0, "mrst");
    send_byte(8'hEE, 0, 1'b0, "mrst");
    valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_words", {47'd0, out_words_written}, 64'd0);
    chk("mrst_busy",  {63'd0, out_busy},          64'd0);
    repeat (2) @(negedge clk);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Write-side companion to the instruction memory. Accepts a byte stream over a valid/ready handshake and packs each group of four bytes into a 32-bit instruction word. Writes each word into the instruction memory write port at consecutive addresses from a programmed base. Lets the test harness or boot logic load a program at run time instead of from a preloaded text image.

## Interface
Parameters:
- ADDR_W, 16, word-address width of the instruction memory (65536 words)

Ports (clock, then reset):
- in_clk  input  1  single clock; all state changes on rising edge
- in_reset_n  input  1  reset, synchronous and active-low
- in_start  input  1  one-cycle pulse; begins a load; honoured only in IDLE or DONE
- in_abort  input  1  cancels the current load; honoured in LOAD or WRITE
- in_base_addr  input  ADDR_W  first word address; sampled when start is accepted
- in_word_count  input  ADDR_W+1  number of words to load; sampled when start is accepted
- in_byte  input  8  stream data
- in_byte_valid  input  1  stream data valid
- out_byte_ready  output  1  loader can accept a byte this cycle
- out_we  output  1  instruction memory write enable, one-cycle pulse per word
- out_waddr  output  ADDR_W  instruction memory write address
- out_wdata  output  32  instruction memory write data
- out_busy  output  1  high in LOAD and WRITE
- out_done  output  1  high in DONE
- out_words_written  output  ADDR_W+1  words committed in the current or last load

## Operation
- States and transitions:
  - IDLE: start → LOAD.
  - LOAD: fourth byte handshake → WRITE.
  - WRITE: last word → DONE; otherwise → LOAD.
  - DONE: start → LOAD.
  - Abort in LOAD or WRITE → IDLE.
- Start with in_word_count = 0 goes straight to DONE. No writes occur and out_words_written is 0.
- Start actions:
  - Latch base and count.
  - Clear the byte counter and out_words_written.
  - Drop out_done.
- Byte transfer occurs when in_byte_valid && out_byte_ready at a rising edge.
- Byte order is big-endian:
  - 1st byte → bits [31:24]
  - 2nd byte → bits [23:16]
  - 3rd byte → bits [15:8]
  - 4th byte → bits [7:0]
- WRITE state, exactly one cycle:
  - out_we = 1.
  - out_waddr = base + words_written, modulo 2^ADDR_W (wraps past the top of memory).
  - out_wdata = the packed word.
  - On exit, out_words_written increments.
- out_waddr and out_wdata are registered and hold their last values outside WRITE. They are meaningful only when out_we = 1.
- Abort discards any partial word. Words already written stay written, and out_words_written keeps its count. out_done stays 0.
- in_start in LOAD or WRITE is ignored. in_abort in IDLE or DONE is ignored.
- If start and abort arrive in the same cycle:
  - In IDLE or DONE, start wins.
  - In LOAD or WRITE, abort wins.
- Bytes presented while out_byte_ready = 0 are not consumed; the sender holds them.

## Timing
- Reset values: state IDLE, and every output is 0 (out_byte_ready, out_we, out_waddr, out_wdata, out_busy, out_done, out_words_written). The partial-word register and byte counter are also cleared.
- Reset asserted mid-load behaves like abort, except that out_words_written is also cleared.
- out_byte_ready is 1 only in LOAD. It is 0 in IDLE, WRITE and DONE, and in the cycle after start is accepted it is already 1.
- out_byte_ready is a registered state decode, with no combinational path from in_byte_valid.
- Latency: out_we is high in the cycle immediately after the edge that accepted a word's 4th byte.
- Peak throughput: one word per 5 cycles (4 LOAD handshakes + 1 WRITE).
- out_done rises in the cycle after the final WRITE and holds until the next accepted start.

## Structure
- Shared package cpu_pkg holds:
  - WORD_W = 32
  - default ADDR_W
  - enum loader_state_t {IDLE, LOAD, WRITE, DONE}
- Sub-module byte_packer: 2-bit byte counter plus 32-bit shift register.
  - Inputs: shift, clear.
  - Outputs: word, word_full.
  - Reused by a future data-memory loader.
- Top level holds the FSM, the address/count registers and the output registers.

## Test plan
- Reset: hold in_reset_n = 0 for 3 cycles while driving start/valid → all outputs 0, state IDLE, no out_we.
- Basic load: base 0x0010, count 2, bytes 8C 22 00 04 AC 43 00 08 with valid always high → out_we at 0x0010 with 0x8C220004, then at 0x0011 with 0xAC430008; each out_we exactly one cycle after the 4th byte; out_done after the second write; out_words_written = 2.
- Backpressure and gaps: random valid gaps, plus bytes held during WRITE → identical written words; no byte lost or duplicated.
- Wrap-around: base 0xFFFF, count 2 → writes at 0xFFFF then 0x0000.
- Abort and restart: abort after 6 bytes of a 3-word load → exactly one write; IDLE; out_words_written = 1; a following start of count 1 writes correctly with a clean byte counter.
- Edge cases:
  - count 0 → out_done without any out_we.
  - start during LOAD → ignored.
  - start and abort in the same cycle from DONE → new load begins.
